// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: instruction-memory fetch controller.
// A single demand entry holds the last fetched word. Misses on legal,
// word-aligned addresses are fetched from backing memory through a
// registered mem_req/mem_addr handshake. Illegal addresses answer at once
// with a zero word, so the fetch stage can raise its own address error.
// Optional feature: define IM_PREFETCH_EN to add a next-word prefetch entry
// and a PF state that fetches A+4 after every demand fill of A.
module im_fetch_ctrl #(
    parameter logic [31:0] IM_ADDR_START = 32'h0000_3000,
    parameter logic [31:0] IM_ADDR_END   = 32'h0000_3FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IAddr,
    output logic [31:0] IRData,
    output logic        IReady,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

`ifdef IM_PREFETCH_EN
    typedef enum logic [1:0] {IDLE, BUSY, PF} state_t;
`else
    typedef enum logic {IDLE, BUSY} state_t;
`endif

    state_t      state;

    // Demand entry
    logic        dvalid;
    logic [31:0] daddr;
    logic [31:0] ddata;

    // Set when an invalidate arrives while a request is in flight; the
    // returning word is then stale and must not be installed.
    logic        drop_fill;

`ifdef IM_PREFETCH_EN
    // Prefetch entry
    logic        pvalid;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        p_hit;
    logic [31:0] pf_addr;
`endif

    logic        addr_legal;
    logic        d_hit;
    logic        any_hit;
    logic        fetch_miss;

    // An address is fetchable only inside the instruction window and aligned.
    function automatic logic is_legal(input logic [31:0] a);
        return (a >= IM_ADDR_START) && (a <= IM_ADDR_END) && (a[1:0] == 2'b00);
    endfunction

    assign addr_legal = is_legal(IAddr);

    // An invalidate in this cycle suppresses hits immediately.
    assign d_hit = dvalid && (daddr == IAddr) && !inv;

`ifdef IM_PREFETCH_EN
    assign p_hit   = pvalid && (paddr == IAddr) && !inv;
    assign any_hit = d_hit || p_hit;
    assign pf_addr = mem_addr + 32'd4;
`else
    assign any_hit = d_hit;
`endif

    // A legal address that nothing buffered can answer needs a memory read.
    assign fetch_miss = addr_legal && !any_hit && !inv;

    // Answer the fetch stage from buffered state only; mem_ack never reaches IReady.
    always_comb begin
        IReady = 1'b0;
        IRData = 32'd0;
        if (!addr_legal) begin
            IReady = 1'b1;
        end else if (d_hit) begin
            IReady = 1'b1;
            IRData = ddata;
`ifdef IM_PREFETCH_EN
        end else if (p_hit) begin
            IReady = 1'b1;
            IRData = pdata;
`endif
        end
    end

    // Request FSM, memory handshake registers and buffered entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            dvalid    <= 1'b0;
            daddr     <= 32'd0;
            ddata     <= 32'd0;
            drop_fill <= 1'b0;
`ifdef IM_PREFETCH_EN
            pvalid    <= 1'b0;
            paddr     <= 32'd0;
            pdata     <= 32'd0;
`endif
        end else begin
            if (inv) begin
                dvalid <= 1'b0;
`ifdef IM_PREFETCH_EN
                pvalid <= 1'b0;
`endif
            end

            case (state)
                IDLE: begin
                    // Acks arriving here belong to nothing and are ignored.
                    if (fetch_miss) begin
                        state     <= BUSY;
                        mem_req   <= 1'b1;
                        mem_addr  <= IAddr;
                        drop_fill <= 1'b0;
                    end
                end

                BUSY: begin
                    // The request runs to completion even if IAddr moves away;
                    // the new address is looked at again once back in IDLE.
                    if (inv) begin
                        drop_fill <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        if (!drop_fill && !inv) begin
                            dvalid <= 1'b1;
                            daddr  <= mem_addr;
                            ddata  <= mem_rdata;
                        end
`ifdef IM_PREFETCH_EN
                        if (!drop_fill && !inv && is_legal(pf_addr)) begin
                            state     <= PF;
                            mem_req   <= 1'b1;
                            mem_addr  <= pf_addr;
                            drop_fill <= 1'b0;
                        end
`endif
                    end
                end

`ifdef IM_PREFETCH_EN
                PF: begin
                    // A demand miss during a prefetch waits here; IDLE then
                    // re-evaluates it, possibly hitting the word just fetched.
                    if (inv) begin
                        drop_fill <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        if (!drop_fill && !inv) begin
                            pvalid <= 1'b1;
                            paddr  <= mem_addr;
                            pdata  <= mem_rdata;
                        end
                    end
                end
`endif

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl: self-checking bench for im_fetch_ctrl (default build).
// A behavioural model tracks the buffered word and the outstanding request
// as a queue; a negedge compare process checks the DUT against it every
// cycle and also checks a set of hand-computed literal expectations.
module tb_im_fetch_ctrl;

    localparam logic [31:0] IM_START = 32'h0000_3000;
    localparam logic [31:0] IM_END   = 32'h0000_3FFC;

    logic        clk;
    logic        reset;
    logic [31:0] IAddr;
    logic [31:0] IRData;
    logic        IReady;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] outstanding[$];
    bit          dropped;

    // Literal expectation handed from the stimulus process to the checker
    bit          check_en;
    bit          lit_en;
    string       lit_name;
    logic        lit_ready;
    logic [31:0] lit_data;
    logic        lit_req;
    logic [31:0] lit_addr;

    im_fetch_ctrl #(
        .IM_ADDR_START(IM_START),
        .IM_ADDR_END  (IM_END)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .IAddr    (IAddr),
        .IRData   (IRData),
        .IReady   (IReady),
        .inv      (inv),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit legal(input logic [31:0] a);
        return (a >= IM_START) && (a <= IM_END) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Model: one buffered word, at most one outstanding read, stale reads dropped.
    always @(posedge clk) begin : model_update
        logic [31:0] popped;
        bit hit_now;
        if (reset) begin
            m_valid = 0;
            m_addr  = 32'd0;
            m_data  = 32'd0;
            dropped = 0;
            outstanding.delete();
        end else begin
            hit_now = m_valid && (m_addr == IAddr) && !inv;
            if (inv) m_valid = 0;
            if (outstanding.size() == 0) begin
                if (legal(IAddr) && !hit_now && !inv) begin
                    outstanding.push_back(IAddr);
                    dropped = 0;
                end
            end else begin
                if (inv) dropped = 1;
                if (mem_ack) begin
                    popped = outstanding.pop_front();
                    if (!dropped) begin
                        m_valid = 1;
                        m_addr  = popped;
                        m_data  = mem_rdata;
                    end
                end
            end
        end
    end

    // Compare process: model check every cycle, plus literal expectations.
    always @(negedge clk) begin : compare
        logic        e_ready;
        logic [31:0] e_data;
        logic        e_req;
        logic [31:0] e_addr;
        bit          hit;
        if (check_en) begin
            if (reset) begin
                e_ready = !legal(IAddr);
                e_data  = 32'd0;
                e_req   = 1'b0;
                e_addr  = 32'd0;
                cmp("model.mem_addr_rst", mem_addr, e_addr);
            end else begin
                hit     = m_valid && (m_addr == IAddr) && !inv;
                e_ready = !legal(IAddr) || hit;
                e_data  = hit ? m_data : 32'd0;
                e_req   = (outstanding.size() != 0);
                e_addr  = e_req ? outstanding[0] : 32'd0;
                if (e_req) cmp("model.mem_addr", mem_addr, e_addr);
            end
            cmp("model.IReady", {31'd0, IReady}, {31'd0, e_ready});
            cmp("model.IRData", IRData, e_data);
            cmp("model.mem_req", {31'd0, mem_req}, {31'd0, e_req});
        end
        if (lit_en) begin
            cmp({lit_name, ".IReady"}, {31'd0, IReady}, {31'd0, lit_ready});
            cmp({lit_name, ".IRData"}, IRData, lit_data);
            cmp({lit_name, ".mem_req"}, {31'd0, mem_req}, {31'd0, lit_req});
            if (lit_req || reset) cmp({lit_name, ".mem_addr"}, mem_addr, lit_addr);
        end
    end

    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic i,
                                 input logic k, input logic [31:0] d);
        reset     = r;
        IAddr     = a;
        inv       = i;
        mem_ack   = k;
        mem_rdata = d;
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic i,
                        input logic k, input logic [31:0] d);
        @(posedge clk);
        #1;
        applyStimulus(r, a, i, k, d);
    endtask

    task automatic checkOutput(input string name, input logic rdy, input logic [31:0] data,
                               input logic req, input logic [31:0] addr);
        lit_name  = name;
        lit_ready = rdy;
        lit_data  = data;
        lit_req   = req;
        lit_addr  = addr;
        lit_en    = 1'b1;
        @(negedge clk);
        #1;
        lit_en    = 1'b0;
    endtask

    logic [31:0] pool [8];

    initial begin : stimulus
        logic [31:0] addr;
        logic        r_rst;
        logic        r_inv;
        logic        ack;
        logic [31:0] rd;
        bit          pend;
        int          cnt;

        checks   = 0;
        errors   = 0;
        lit_en   = 1'b0;
        check_en = 1'b1;
        pend     = 0;
        cnt      = 0;
        pool[0] = 32'h0000_3000; pool[1] = 32'h0000_3004;
        pool[2] = 32'h0000_3010; pool[3] = 32'h0000_3FFC;
        pool[4] = 32'h0000_4000; pool[5] = 32'h0000_2FFC;
        pool[6] = 32'h0000_3002; pool[7] = 32'h0000_0000;

        // Reset with the boot PC on the bus: legal, nothing buffered.
        applyStimulus(1, 32'h3000, 0, 0, 0);
        checkOutput("reset", 0, 0, 0, 0);
        step(1, 32'h3000, 0, 0, 0);

        // First miss: request next cycle, ack one cycle later, data three cycles after miss.
        step(0, 32'h3000, 0, 0, 0);
        checkOutput("miss_cycle", 0, 0, 0, 0);
        step(0, 32'h3000, 0, 0, 0);
        checkOutput("req_issue", 0, 0, 1, 32'h3000);
        step(0, 32'h3000, 0, 1, 32'h2408_0001);
        checkOutput("ack_cycle", 0, 0, 1, 32'h3000);
        step(0, 32'h3000, 0, 0, 0);
        checkOutput("first_hit", 1, 32'h2408_0001, 0, 0);
        for (int n = 0; n < 3; n++) begin
            step(0, 32'h3000, 0, 0, 0);
            checkOutput("hold_hit", 1, 32'h2408_0001, 0, 0);
        end

        // Illegal addresses: misaligned, zero, one past the window, one below it.
        step(0, 32'h3002, 0, 0, 0);
        checkOutput("misaligned", 1, 0, 0, 0);
        step(0, 32'h0000, 0, 0, 0);
        checkOutput("zero_addr", 1, 0, 0, 0);
        step(0, 32'h4000, 0, 0, 0);
        checkOutput("above_end", 1, 0, 0, 0);
        step(0, 32'h2FFC, 0, 0, 0);
        checkOutput("below_start", 1, 0, 0, 0);

        // Invalidate suppresses the hit in the same cycle.
        step(0, 32'h3000, 1, 0, 0);
        checkOutput("inv_suppress", 0, 0, 0, 0);

        // Redirect while busy: 0x3000 completes, then 0x3010 is fetched.
        step(0, 32'h3000, 0, 0, 0);
        checkOutput("redir_miss", 0, 0, 0, 0);
        step(0, 32'h3010, 0, 0, 0);
        checkOutput("redir_busy", 0, 0, 1, 32'h3000);
        step(0, 32'h3010, 0, 1, 32'h1111_1111);
        checkOutput("redir_ack", 0, 0, 1, 32'h3000);
        step(0, 32'h3010, 0, 0, 0);
        checkOutput("redir_remiss", 0, 0, 0, 0);
        step(0, 32'h3010, 0, 1, 32'h2222_2222);
        checkOutput("redir_req2", 0, 0, 1, 32'h3010);
        step(0, 32'h3010, 0, 0, 0);
        checkOutput("redir_hit", 1, 32'h2222_2222, 0, 0);

        // Invalidate on the ack cycle discards the word; the address re-requests.
        step(0, 32'h3000, 0, 0, 0);
        checkOutput("inv_miss", 0, 0, 0, 0);
        step(0, 32'h3000, 1, 1, 32'h3333_3333);
        checkOutput("inv_ack", 0, 0, 1, 32'h3000);
        step(0, 32'h3000, 0, 0, 0);
        checkOutput("inv_dropped", 0, 0, 0, 0);
        step(0, 32'h3000, 0, 1, 32'h4444_4444);
        checkOutput("inv_rereq", 0, 0, 1, 32'h3000);
        step(0, 32'h3000, 0, 0, 0);
        checkOutput("inv_refill", 1, 32'h4444_4444, 0, 0);

        // Reset in BUSY abandons the request; a late ack is ignored.
        step(0, 32'h3004, 0, 0, 0);
        checkOutput("rst_miss", 0, 0, 0, 0);
        step(0, 32'h3004, 0, 0, 0);
        checkOutput("rst_busy", 0, 0, 1, 32'h3004);
        step(1, 32'h3004, 0, 0, 0);
        checkOutput("rst_mid", 0, 0, 0, 0);
        step(0, 32'h3004, 0, 1, 32'h5555_5555);
        checkOutput("late_ack", 0, 0, 0, 0);
        step(0, 32'h3004, 0, 1, 32'h6666_6666);
        checkOutput("rst_rereq", 0, 0, 1, 32'h3004);
        step(0, 32'h3004, 0, 0, 0);
        checkOutput("rst_refill", 1, 32'h6666_6666, 0, 0);

        // Randomised traffic against the model with a variable-latency memory.
        addr = 32'h3004;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            r_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 30) addr = pool[$urandom_range(0, 7)];
            r_inv = ($urandom_range(0, 19) == 0);
            if (mem_req) begin
                if (!pend) begin
                    pend = 1;
                    cnt  = $urandom_range(0, 3);
                end
                if (cnt == 0) begin
                    ack  = 1'b1;
                    rd   = memword(mem_addr);
                    pend = 0;
                end else begin
                    ack = 1'b0;
                    rd  = $urandom;
                    cnt--;
                end
            end else begin
                pend = 0;
                ack  = ($urandom_range(0, 7) == 0);
                rd   = $urandom;
            end
            applyStimulus(r_rst, addr, r_inv, ack, rd);
        end

        step(0, 32'h3000, 0, 0, 0);
        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
